// File: rtl/fadd_accumulator.sv
// Packet accumulator front-end for an external combinational single-precision adder.
// Optional NaN poisoning is enabled by defining FADD_ACC_NAN_STICKY_EN.
module fadd_accumulator #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        in_data_i,
  input  logic               in_last_i,
  output logic [31:0]        fadd_a_o,
  output logic [31:0]        fadd_b_o,
  input  logic [31:0]        fadd_out_i,
  output logic               sum_valid_o,
  input  logic               sum_ready_i,
  output logic [31:0]        sum_data_o,
  output logic [COUNT_W-1:0] sum_count_o,
  output logic               sum_nan_o
);

  typedef enum logic [1:0] {StIdle, StAccum, StAdd, StDone} state_e;

  state_e             state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        fadd_a_q, fadd_a_d;
  logic [31:0]        fadd_b_q, fadd_b_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               last_q, last_d;

`ifdef FADD_ACC_NAN_STICKY_EN
  localparam logic [31:0] QNaN = 32'h7FC0_0000;
  logic nan_q, nan_d;
  logic out_is_nan;
  assign out_is_nan = (fadd_out_i[30:23] == 8'hFF) && (fadd_out_i[22:0] != 23'd0);
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fadd_a_d    = fadd_a_q;
    fadd_b_d    = fadd_b_q;
    count_d     = count_q;
    last_d      = last_q;
`ifdef FADD_ACC_NAN_STICKY_EN
    nan_d       = nan_q;
`endif
    in_ready_o  = 1'b0;
    sum_valid_o = 1'b0;
    sum_data_o  = 32'd0;
    sum_count_o = '0;
    unique case (state_q)
      StIdle: begin
        // Ready is masked while reset is held so nothing is accepted in reset.
        in_ready_o = rst_ni;
        acc_d      = 32'd0;
        if (in_valid_i) begin
          fadd_a_d = 32'd0;
          fadd_b_d = in_data_i;
          last_d   = in_last_i;
          count_d  = COUNT_W'(1);
          state_d  = StAdd;
        end
      end
      StAccum: begin
        in_ready_o = rst_ni;
        if (in_valid_i) begin
          fadd_a_d = acc_q;
          fadd_b_d = in_data_i;
          last_d   = in_last_i;
          count_d  = (&count_q) ? count_q : count_q + COUNT_W'(1);
          state_d  = StAdd;
        end
      end
      StAdd: begin
`ifdef FADD_ACC_NAN_STICKY_EN
        if (nan_q || out_is_nan) begin
          acc_d = QNaN;
          nan_d = 1'b1;
        end else begin
          acc_d = fadd_out_i;
        end
`else
        acc_d = fadd_out_i;
`endif
        state_d = last_q ? StDone : StAccum;
      end
      StDone: begin
        sum_valid_o = 1'b1;
        sum_data_o  = acc_q;
        sum_count_o = count_q;
        if (sum_ready_i) begin
          acc_d   = 32'd0;
          count_d = '0;
`ifdef FADD_ACC_NAN_STICKY_EN
          nan_d   = 1'b0;
`endif
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      acc_q    <= 32'd0;
      fadd_a_q <= 32'd0;
      fadd_b_q <= 32'd0;
      count_q  <= '0;
      last_q   <= 1'b0;
`ifdef FADD_ACC_NAN_STICKY_EN
      nan_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      fadd_a_q <= fadd_a_d;
      fadd_b_q <= fadd_b_d;
      count_q  <= count_d;
      last_q   <= last_d;
`ifdef FADD_ACC_NAN_STICKY_EN
      nan_q    <= nan_d;
`endif
    end
  end

  assign fadd_a_o = fadd_a_q;
  assign fadd_b_o = fadd_b_q;

`ifdef FADD_ACC_NAN_STICKY_EN
  assign sum_nan_o = (state_q == StDone) && nan_q;
`else
  assign sum_nan_o = 1'b0;
`endif

endmodule

// File: tb/tb_fadd_accumulator.sv
// Directed bench for fadd_accumulator; supplies a behavioural float adder on fadd_out.
module tb_fadd_accumulator;

  localparam int unsigned CW = 4;  // small counter so saturation is reachable

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          in_valid, in_ready, in_last;
  logic [31:0]   in_data;
  logic [31:0]   fadd_a, fadd_b, fadd_out;
  logic          sum_valid, sum_ready, sum_nan;
  logic [31:0]   sum_data;
  logic [CW-1:0] sum_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fadd_accumulator #(.COUNT_W(CW)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .fadd_a_o    (fadd_a),
    .fadd_b_o    (fadd_b),
    .fadd_out_i  (fadd_out),
    .sum_valid_o (sum_valid),
    .sum_ready_i (sum_ready),
    .sum_data_o  (sum_data),
    .sum_count_o (sum_count),
    .sum_nan_o   (sum_nan)
  );

  function automatic real f2r(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic        s;
    real         a;
    int          e;
    logic [22:0] fr;
    if (r == 0.0) return 32'd0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    if (e <= 0) return {s, 31'd0};
    fr = 23'($rtoi((a - 1.0) * 8388608.0));
    return {s, 8'(e), fr};
  endfunction

  function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC0_0000;
    return r2f(f2r(a) + f2r(b));
  endfunction

  always_comb fadd_out = fadd_model(fadd_a, fadd_b);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the last element was accepted.
  task automatic finish_pkt(input string tag, input logic [31:0] exp_data, input int exp_cnt,
                            input logic exp_nan);
    @(negedge clk);
    check_eq({tag, "_valid_add"}, {31'd0, sum_valid}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_valid"}, {31'd0, sum_valid}, 32'd1);
    check_eq({tag, "_data"}, sum_data, exp_data);
    check_eq({tag, "_count"}, 32'(sum_count), 32'(exp_cnt));
    check_eq({tag, "_nan"}, {31'd0, sum_nan}, {31'd0, exp_nan});
    check_eq({tag, "_rdy_done"}, {31'd0, in_ready}, 32'd0);
    sum_ready = 1'b1;
    @(posedge clk);
    #1;
    sum_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, "_valid_drop"}, {31'd0, sum_valid}, 32'd0);
    check_eq({tag, "_rdy_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_ni    = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = 32'd0;
    sum_ready = 1'b0;
    #2;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
    check_eq("rst_sum_data", sum_data, 32'd0);
    check_eq("rst_sum_count", 32'(sum_count), 32'd0);
    check_eq("rst_fadd_a", fadd_a, 32'd0);
    check_eq("rst_fadd_b", fadd_b, 32'd0);
    check_eq("rst_sum_nan", {31'd0, sum_nan}, 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    // 1 + 2 + 3 = 6
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    send(32'h4040_0000, 1'b1);
    check_eq("p3_fadd_a", fadd_a, 32'h4040_0000);
    check_eq("p3_fadd_b", fadd_b, 32'h4040_0000);
    finish_pkt("p3", 32'h40C0_0000, 3, 1'b0);

    send(32'h3F80_0000, 1'b1);
    finish_pkt("single", 32'h3F80_0000, 1, 1'b0);

    send(32'h3F80_0000, 1'b0);
    send(32'hBF80_0000, 1'b1);
    finish_pkt("cancel", 32'h0000_0000, 2, 1'b0);

    // Backpressure: DONE held, stray input must be ignored.
    send(32'h4000_0000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_valid", {31'd0, sum_valid}, 32'd1);
      check_eq("hold_data", sum_data, 32'h4000_0000);
      check_eq("hold_count", 32'(sum_count), 32'd1);
      check_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("hold_fadd_b", fadd_b, 32'h4000_0000);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    sum_ready = 1'b1;
    @(posedge clk);
    #1;
    sum_ready = 1'b0;
    @(negedge clk);
    check_eq("hold_release_valid", {31'd0, sum_valid}, 32'd0);
    check_eq("hold_release_rdy", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a 4-element packet.
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("mid_rst_valid", {31'd0, sum_valid}, 32'd0);
    check_eq("mid_rst_fadd_a", fadd_a, 32'd0);
    check_eq("mid_rst_fadd_b", fadd_b, 32'd0);
    check_eq("mid_rst_count", 32'(sum_count), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    send(32'h4000_0000, 1'b1);
    finish_pkt("after_rst", 32'h4000_0000, 1, 1'b0);

    // 17 ones: sum 17.0, count saturates at 15.
    for (int i = 0; i < 17; i++) send(32'h3F80_0000, (i == 16));
    finish_pkt("sat", 32'h4188_0000, 15, 1'b0);

`ifdef FADD_ACC_NAN_STICKY_EN
    send(32'h3F80_0000, 1'b0);
    send(32'h7FC0_0001, 1'b0);
    send(32'h3F80_0000, 1'b1);
    finish_pkt("nan", 32'h7FC0_0000, 3, 1'b1);
    send(32'h3F80_0000, 1'b1);
    finish_pkt("nan_clear", 32'h3F80_0000, 1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
